truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequences a 3-input combinational gate-level circuit, such as a NOR/NOT genetic-logic design, through all 2^N_IN input rows.
- Holds each row for a programmable settle time, then samples the circuit output.
- Builds the measured truth-table hex word and compares it against an expected word.
- Sits between the test/scoring harness and the circuit under evaluation, and owns the circuit's input drive exclusively.

Parameters:
- N_IN, 3, number of circuit inputs; TT_W = 2^N_IN truth-table bits.
- SETTLE_CYCLES, 16, cycles each input row is held before sampling; legal range is 1 or more.
- CNT_W, 16, width of the settle counter; must satisfy SETTLE_CYCLES < 2^CNT_W.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a sweep; accepted only in IDLE.
- abort  input  1  terminates an active sweep.
- expected_tt  input  TT_W  expected truth table; captured when start is accepted.
- circ_in  output  N_IN  drive to the circuit inputs; bit N_IN-1 = in1, bit N_IN-2 = in2, bit 0 = in3 (N_IN=3).
- circ_out  input  1  circuit output being measured.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes normally.
- aborted  output  1  one-cycle pulse when a sweep is terminated by abort.
- measured_tt  output  TT_W  measured truth table.
- pass  output  1  measured_tt == captured expected word; valid from the done pulse.
- mismatch_cnt  output  N_IN+1  number of rows that differ.
- first_fail_row  output  N_IN  lowest-index row that differs; 0 if none.

Behaviour:
- Row/bit convention (fixed): row r = {in1,in2,in3} as an unsigned integer. The result for row r lands in measured_tt[TT_W-1-r], so hex MSB = row 0 (Cello ordering). Example: a circuit whose output is 1 only on rows 0, 1 and 6 yields 0xC2.
- Reset values (async on rst): state=IDLE, circ_in=0, busy=0, done=0, aborted=0, measured_tt=0, pass=0, mismatch_cnt=0, first_fail_row=0, internal row/settle counters=0.
- States: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE:
  - On start=1 (and abort=0): capture expected_tt.
  - Clear measured_tt, mismatch_cnt, first_fail_row and pass.
  - Set row=0, circ_in=0, busy=1, and go to SETTLE with cnt=0.
- SETTLE:
  - circ_in = row, held constant; cnt increments each cycle.
  - When cnt == SETTLE_CYCLES-1, go to SAMPLE.
  - Row r is therefore driven for SETTLE_CYCLES cycles before SAMPLE.
- SAMPLE (one cycle, circ_in still = row):
  - Write circ_out into measured_tt[TT_W-1-row].
  - If it differs from expected bit [TT_W-1-row], increment mismatch_cnt; if this is the first mismatch, set first_fail_row=row.
  - If row == TT_W-1, go to FINISH. Otherwise row+1, cnt=0, go to SETTLE.
  - No wrap of row: exactly TT_W rows per sweep.
- FINISH (one cycle):
  - pass = (mismatch_cnt == 0); done=1 for this single cycle.
  - busy=0 on exit; circ_in returns to 0; go to IDLE.
- Latency: the start-accept edge to the done pulse is TT_W*(SETTLE_CYCLES+1)+1 cycles. For N_IN=3, SETTLE_CYCLES=4, that is 41.
- Result outputs hold their values until the next accepted start.
- start while busy is ignored; there is no queueing.
- start and abort together in IDLE: abort wins, start is dropped, and no pulse is generated.
- abort while busy (any non-IDLE state):
  - Next edge: IDLE, busy=0, circ_in=0, aborted=1 for one cycle, done not asserted.
  - measured_tt and mismatch_cnt keep partial values; pass=0.
  - If abort lands in FINISH, abort wins.
- abort in IDLE is a no-op.
- rst asserted mid-sweep clears everything immediately, with no pulse. The first start after rst deasserts begins a fresh sweep.
- circ_out is treated as synchronous. Any synchronizer is external; its latency must be covered by SETTLE_CYCLES.

Test Plan:
- Correct circuit: model circuit = 0xC2 function, expected_tt=0xC2, SETTLE_CYCLES=4, pulse start -> circ_in steps 0..7 with 5 cycles per row; done exactly 41 cycles after accept; measured_tt=0xC2, pass=1, mismatch_cnt=0, first_fail_row=0.
- Single-row mismatch: same circuit, expected_tt=0xC3 -> measured_tt=0xC2, pass=0, mismatch_cnt=1, first_fail_row=7.
- Abort mid-sweep: abort raised while circ_in=3 -> next cycle busy=0, circ_in=0, aborted pulses once, done never pulses, pass=0, measured_tt bits for rows 0-2 hold 1,1,0 (0xC0 pattern in the top 3 bits).
- Start while busy: a second start during row 5 -> ignored; sweep finishes at the original cycle count with the original expected_tt.
- Async reset: rst asserted during row 6 between clock edges -> all outputs return to reset values immediately; a new start then yields a full clean sweep (done after 41 cycles).
- Output stuck at 1: expected_tt=0x00, circ_out tied to 1 -> measured_tt=0xFF, mismatch_cnt=8, first_fail_row=0, pass=0.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Steps a small combinational circuit through every input row, samples its output after a
// settle delay, and scores the measured truth table against an expected word.
module truth_table_sweeper #(
  parameter  int N_IN          = 3,
  parameter  int SETTLE_CYCLES = 16,
  parameter  int CNT_W         = 16,
  localparam int TT_W          = 1 << N_IN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [TT_W-1:0]   expected_tt,
  output logic [N_IN-1:0]   circ_in,
  input  logic              circ_out,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [TT_W-1:0]   measured_tt,
  output logic              pass,
  output logic [N_IN:0]     mismatch_cnt,
  output logic [N_IN-1:0]   first_fail_row
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t            state_r;
  logic [N_IN-1:0]   row_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [TT_W-1:0]   exp_r;
  logic [N_IN-1:0]   bit_idx_s;
  logic              sample_bad_s;

  // Row r lands at bit TT_W-1-r, which for a power-of-two table is simply ~r.
  assign bit_idx_s    = ~row_r;
  assign sample_bad_s = circ_out ^ exp_r[bit_idx_s];

  // Sweep sequencer: drives circ_in, samples circ_out and accumulates the score.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      row_r          <= '0;
      cnt_r          <= '0;
      exp_r          <= '0;
      circ_in        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
      measured_tt    <= '0;
      pass           <= 1'b0;
      mismatch_cnt   <= '0;
      first_fail_row <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      // Abort outranks every in-flight state, including the final scoring cycle.
      if (abort && (state_r != IDLE)) begin
        state_r <= IDLE;
        row_r   <= '0;
        cnt_r   <= '0;
        circ_in <= '0;
        busy    <= 1'b0;
        aborted <= 1'b1;
        pass    <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (start && !abort) begin
              exp_r          <= expected_tt;
              measured_tt    <= '0;
              mismatch_cnt   <= '0;
              first_fail_row <= '0;
              pass           <= 1'b0;
              row_r          <= '0;
              cnt_r          <= '0;
              circ_in        <= '0;
              busy           <= 1'b1;
              state_r        <= SETTLE;
            end else begin
              state_r <= IDLE;
            end
          end
          SETTLE: begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == CNT_W'(SETTLE_CYCLES - 1)) begin
              state_r <= SAMPLE;
            end else begin
              state_r <= SETTLE;
            end
          end
          SAMPLE: begin
            measured_tt[bit_idx_s] <= circ_out;
            if (sample_bad_s) begin
              mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
              if (mismatch_cnt == '0) begin
                first_fail_row <= row_r;
              end else begin
                first_fail_row <= first_fail_row;
              end
            end else begin
              mismatch_cnt <= mismatch_cnt;
            end
            if (row_r == {N_IN{1'b1}}) begin
              state_r <= FINISH;
            end else begin
              row_r   <= row_r + N_IN'(1);
              circ_in <= row_r + N_IN'(1);
              cnt_r   <= '0;
              state_r <= SETTLE;
            end
          end
          FINISH: begin
            pass    <= (mismatch_cnt == '0);
            done    <= 1'b1;
            busy    <= 1'b0;
            circ_in <= '0;
            row_r   <= '0;
            state_r <= IDLE;
          end
          default: begin
            state_r <= IDLE;
            busy    <= 1'b0;
            circ_in <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with SETTLE_CYCLES=4 and a table-driven model circuit.
module tb_truth_table_sweeper;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] expected_tt;
  logic [2:0] circ_in;
  logic       circ_out;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [7:0] measured_tt;
  logic       pass;
  logic [3:0] mismatch_cnt;
  logic [2:0] first_fail_row;
  logic [7:0] tt_func;

  int tests_run = 0;
  int tests_failed = 0;
  int lat;
  int seq_err;
  int done_seen;

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .expected_tt(expected_tt),
    .circ_in(circ_in), .circ_out(circ_out), .busy(busy), .done(done), .aborted(aborted),
    .measured_tt(measured_tt), .pass(pass), .mismatch_cnt(mismatch_cnt),
    .first_fail_row(first_fail_row)
  );

  // Model circuit: row r reads bit 7-r of the function word.
  assign circ_out = tt_func[3'd7 - circ_in];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Starts a sweep and follows it edge by edge; stops at done, aborted, reset or a timeout.
  task automatic run_sweep(input logic [7:0] exp_word, input int restart_k, input int abort_k,
                           input int rst_k, output int lat_o, output int seq_err_o);
    int row_exp;
    lat_o = -1;
    seq_err_o = 0;
    expected_tt = exp_word;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      start = (k == restart_k);
      if (k == restart_k) expected_tt = 8'h00;
      abort = (k == abort_k);
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      if (k == rst_k) begin
        #2 rst = 1'b1;
        #1;
        lat_o = k;
        return;
      end
      if (done || aborted) begin
        lat_o = k;
        return;
      end
      row_exp = (k / 5 > 7) ? 7 : k / 5;
      if (circ_in !== 3'(row_exp) || busy !== 1'b1) seq_err_o++;
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    expected_tt = 8'h00;
    tt_func = 8'hC2;
    #3;
    check_value("rst_busy", busy, 0);
    check_value("rst_circ_in", circ_in, 0);
    check_value("rst_done", done, 0);
    check_value("rst_measured", measured_tt, 0);
    check_value("rst_mismatch", mismatch_cnt, 0);
    #9 rst = 1'b0;
    @(posedge clk);
    #1;

    // Correct circuit
    run_sweep(8'hC2, -1, -1, -1, lat, seq_err);
    check_value("ok_latency", lat, 41);
    check_value("ok_row_seq", seq_err, 0);
    check_value("ok_measured", measured_tt, 8'hC2);
    check_value("ok_pass", pass, 1);
    check_value("ok_mismatch", mismatch_cnt, 0);
    check_value("ok_first_fail", first_fail_row, 0);
    check_value("ok_busy_low", busy, 0);
    check_value("ok_circ_in_idle", circ_in, 0);
    repeat (3) @(posedge clk);
    #1;
    check_value("ok_done_pulse", done, 0);
    check_value("ok_hold", measured_tt, 8'hC2);

    // Single-row mismatch
    run_sweep(8'hC3, -1, -1, -1, lat, seq_err);
    check_value("mm_latency", lat, 41);
    check_value("mm_measured", measured_tt, 8'hC2);
    check_value("mm_pass", pass, 0);
    check_value("mm_mismatch", mismatch_cnt, 1);
    check_value("mm_first_fail", first_fail_row, 7);

    // Abort while row 3 is driven
    run_sweep(8'hC2, -1, 17, -1, lat, seq_err);
    check_value("ab_latency", lat, 17);
    check_value("ab_row_seq", seq_err, 0);
    check_value("ab_aborted", aborted, 1);
    check_value("ab_done", done, 0);
    check_value("ab_busy", busy, 0);
    check_value("ab_circ_in", circ_in, 0);
    check_value("ab_measured", measured_tt, 8'hC0);
    check_value("ab_pass", pass, 0);
    done_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (done || aborted || busy) done_seen++;
    end
    check_value("ab_quiet_after", done_seen, 0);

    // Second start during row 5 with a different expected word
    run_sweep(8'hC2, 27, -1, -1, lat, seq_err);
    check_value("sb_latency", lat, 41);
    check_value("sb_row_seq", seq_err, 0);
    check_value("sb_pass", pass, 1);
    check_value("sb_mismatch", mismatch_cnt, 0);
    @(posedge clk);
    #1;
    check_value("sb_no_restart", busy, 0);

    // Async reset during row 6, then a clean sweep
    run_sweep(8'hC3, -1, -1, 32, lat, seq_err);
    check_value("rs_busy", busy, 0);
    check_value("rs_circ_in", circ_in, 0);
    check_value("rs_measured", measured_tt, 0);
    check_value("rs_mismatch", mismatch_cnt, 0);
    check_value("rs_pass", pass, 0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check_value("rs_idle", busy, 0);
    run_sweep(8'hC2, -1, -1, -1, lat, seq_err);
    check_value("rs_latency", lat, 41);
    check_value("rs_row_seq", seq_err, 0);
    check_value("rs_pass_after", pass, 1);

    // Output stuck at 1
    tt_func = 8'hFF;
    run_sweep(8'h00, -1, -1, -1, lat, seq_err);
    check_value("st_measured", measured_tt, 8'hFF);
    check_value("st_mismatch", mismatch_cnt, 8);
    check_value("st_first_fail", first_fail_row, 0);
    check_value("st_pass", pass, 0);

    // start and abort together in IDLE, then abort alone in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_value("sa_busy", busy, 0);
    check_value("sa_aborted", aborted, 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    check_value("ai_aborted", aborted, 0);
    check_value("ai_measured_hold", measured_tt, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
